// File: rtl/lwe_decrypt_stream.sv
// Streaming LWE decryptor: accumulates <sk, a> over BEATS beats, takes b on a body beat and decodes (b - <sk, a>) mod q to a plaintext.
// Optional macro DECRYPT_ROUND_EN selects round-to-nearest decoding; without it the decode truncates.
module lwe_decrypt_stream #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 10,
  parameter int LANES              = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   in_sk,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   in_ct,
  input  logic                                in_first,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]          out_result,
  output logic                                out_err
);

  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int PW    = PLAINTEXT_WIDTH;
  localparam int BEATS = DIMENSION / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int DEC_W = CW + PW + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS);

`ifdef DECRYPT_ROUND_EN
  localparam logic [DEC_W-1:0] ROUND = DEC_W'(CIPHERTEXT_MODULUS / 2);
`else
  localparam logic [DEC_W-1:0] ROUND = '0;
`endif

  if (PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH) ||
      CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH) ||
      CIPHERTEXT_WIDTH <= PLAINTEXT_WIDTH ||
      DIMENSION % LANES != 0) begin : g_param_check
    $error("lwe_decrypt_stream: inconsistent parameters");
  end

  typedef enum logic [1:0] {ACCUM, BODY, OUT} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CW-1:0]     acc, acc_next;
  logic [PW-1:0]     result_next;
  logic              err_next;
  logic [CW-1:0]     beat_sum;
  logic [CW-1:0]     phase;
  logic [DEC_W-1:0]  dec;

  // Every product and partial sum is kept at CW bits, which is exactly mod q.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++)
      beat_sum = beat_sum + in_sk[i*CW +: CW] * in_ct[i*CW +: CW];
  end

  assign phase = in_ct[CW-1:0] - acc;
  assign dec   = DEC_W'(phase) * DEC_W'(PLAINTEXT_MODULUS) + ROUND;

  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    acc_next    = acc;
    result_next = out_result;
    err_next    = out_err;
    if (state == OUT) begin
      if (out_ready) state_next = ACCUM;
    end else if (in_valid) begin
      if (in_first) begin
        if (cnt != '0 || state == BODY) err_next = 1'b1;
        acc_next   = beat_sum;
        cnt_next   = CNT_W'(1);
        state_next = ACCUM;
      end else if (state == BODY) begin
        result_next = PW'(dec >> CW);
        state_next  = OUT;
      end else if (cnt == '0) begin
        err_next = 1'b1;
      end else begin
        acc_next = acc + beat_sum;
        cnt_next = cnt + 1'b1;
      end
      if (state_next == ACCUM && cnt_next == LAST_BEAT) begin
        state_next = BODY;
        cnt_next   = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      cnt        <= '0;
      acc        <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      acc        <= acc_next;
      out_result <= result_next;
      out_err    <= err_next;
    end
  end

endmodule

// File: tb/tb_lwe_decrypt_stream.sv
// Self-checking bench for lwe_decrypt_stream: directed and random vectors against an arithmetic reference model.
module tb_lwe_decrypt_stream;

  localparam int T     = 64;
  localparam int PW    = 6;
  localparam int Q     = 1024;
  localparam int CW    = 10;
  localparam int DIM   = 10;
  localparam int LANES = 2;
  localparam int BEATS = DIM / LANES;
  localparam int BW    = LANES * CW;

`ifdef DECRYPT_ROUND_EN
  localparam int RND      = Q / 2;
  localparam int EXP_B88  = 6;
  localparam int EXP_WRAP = 0;
`else
  localparam int RND      = 0;
  localparam int EXP_B88  = 5;
  localparam int EXP_WRAP = 63;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_sk;
  logic [BW-1:0] in_ct;
  logic          in_first;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_result;
  logic          out_err;

  int checks   = 0;
  int failures = 0;
  int sk_v [DIM];
  int a_v  [DIM];

  lwe_decrypt_stream #(
    .PLAINTEXT_MODULUS(T), .PLAINTEXT_WIDTH(PW), .CIPHERTEXT_MODULUS(Q),
    .CIPHERTEXT_WIDTH(CW), .DIMENSION(DIM), .LANES(LANES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sk(in_sk), .in_ct(in_ct), .in_first(in_first), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: inner product mod q, phase = b - acc mod q, scaled by t/q with optional half-q rounding.
  function automatic int model(input int b);
    int acc;
    int phase;
    acc = 0;
    for (int i = 0; i < DIM; i++) acc = (acc + sk_v[i] * a_v[i]) % Q;
    phase = (b - acc + Q) % Q;
    return ((phase * T + RND) / Q) % T;
  endfunction

  function automatic logic [BW-1:0] pack_sk(input int beat);
    logic [BW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*CW +: CW] = CW'(sk_v[beat*LANES + l]);
    return r;
  endfunction

  function automatic logic [BW-1:0] pack_a(input int beat);
    logic [BW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*CW +: CW] = CW'(a_v[beat*LANES + l]);
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < DIM; i++) begin
      sk_v[i] = int'($urandom_range(0, Q - 1));
      a_v[i]  = int'($urandom_range(0, Q - 1));
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic drive_beat(input logic [BW-1:0] sk, input logic [BW-1:0] ct, input logic first);
    int n;
    n = 0;
    in_sk = sk; in_ct = ct; in_first = first; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_a_beats();
    for (int bt = 0; bt < BEATS; bt++) drive_beat(pack_sk(bt), pack_a(bt), bt == 0);
  endtask

  task automatic send_body(input int b);
    logic [BW-1:0] ct;
    ct = BW'($urandom);
    ct[CW-1:0] = CW'(b);
    drive_beat(BW'($urandom), ct, 1'b0);
  endtask

  task automatic collect(input string tag, input int exp);
    logic [PW-1:0] held;
    int stall;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_result"}, out_result, exp);
    held  = out_result;
    stall = int'($urandom_range(0, 2));
    repeat (stall) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_result"}, out_result, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
  endtask

  task automatic run_vector(input int b, input int exp, input string tag);
    send_a_beats();
    send_body(b);
    collect(tag, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int b;
    int exp;
    int seen;
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0;
    in_sk = '0; in_ct = '0; out_ready = 1'b0;

    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_result", out_result, 0);
    check("reset_out_err", out_err, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero key: the phase is b itself.
    for (int i = 0; i < DIM; i++) begin
      sk_v[i] = 0;
      a_v[i]  = int'($urandom_range(0, Q - 1));
    end
    run_vector(88, EXP_B88, "zero_key_b88");
    run_vector(87, 5, "zero_key_b87");

    for (int i = 0; i < DIM; i++) begin
      sk_v[i] = 1;
      a_v[i]  = 1;
    end
    run_vector(90, 5, "ones_b90");

    for (int i = 0; i < DIM; i++) a_v[i] = 0;
    a_v[0] = 8;
    run_vector(0, EXP_WRAP, "wrap_acc8_b0");

    repeat (6) begin
      fill_random();
      b = int'($urandom_range(0, Q - 1));
      run_vector(b, model(b), "random");
    end
    check("err_clean_run", out_err, 1'b0);

    // A non-first beat with no vector open is flagged and dropped.
    drive_beat(BW'($urandom), BW'($urandom), 1'b0);
    check("orphan_beat_err", out_err, 1'b1);
    fill_random();
    b = int'($urandom_range(0, Q - 1));
    run_vector(b, model(b), "after_orphan");

    do_reset();
    check("err_cleared_by_reset", out_err, 1'b0);

    // Output back-pressure with a beat waiting upstream.
    fill_random();
    b = int'($urandom_range(0, Q - 1));
    exp = model(b);
    send_a_beats();
    send_body(b);
    check("stall_result", out_result, exp);
    in_sk = BW'($urandom); in_ct = BW'($urandom); in_first = 1'b1; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_result", out_result, exp);
    end
    in_valid = 1'b0; in_first = 1'b0;
    collect("stall_release", exp);
    fill_random();
    b = int'($urandom_range(0, Q - 1));
    run_vector(b, model(b), "after_stall");
    check("stall_no_consume_err", out_err, 1'b0);

    // in_first on beat 3 abandons the partial vector and restarts.
    for (int bt = 0; bt < 3; bt++) drive_beat(BW'($urandom), BW'($urandom), bt == 0);
    check("pre_restart_err", out_err, 1'b0);
    fill_random();
    send_a_beats();
    check("restart_err", out_err, 1'b1);
    b = int'($urandom_range(0, Q - 1));
    send_body(b);
    collect("restart_result", model(b));

    // Reset while a result is pending.
    fill_random();
    send_a_beats();
    send_body(int'($urandom_range(0, Q - 1)));
    check("pending_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("out_reset_valid", out_valid, 1'b0);
    check("out_reset_result", out_result, 0);
    check("out_reset_err", out_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during beat 2 of a vector, then a full new vector.
    fill_random();
    drive_beat(pack_sk(0), pack_a(0), 1'b1);
    in_sk = pack_sk(1); in_ct = pack_a(1); in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", out_valid, 1'b0);
    check("mid_reset_err", out_err, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    fill_random();
    b = int'($urandom_range(0, Q - 1));
    run_vector(b, model(b), "post_reset");
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("post_reset_extra_results", seen, 0);
    check("post_reset_err", out_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lwe_decrypt_stream.md
LWE_DECRYPT_STREAM -- requirements
Module: lwe_decrypt_stream

Interface
REQ-001 Parameter PLAINTEXT_MODULUS, default 64, plaintext modulus t, power of two.
REQ-002 Parameter PLAINTEXT_WIDTH, default 6, log2(t).
REQ-003 Parameter CIPHERTEXT_MODULUS, default 1024, ciphertext modulus q, power of two, q > t.
REQ-004 Parameter CIPHERTEXT_WIDTH, default 10, log2(q).
REQ-005 Parameter DIMENSION, default 10, LWE vector length n.
REQ-006 Parameter LANES, default 2, products per beat; DIMENSION SHALL be a multiple of LANES; BEATS = DIMENSION/LANES.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  block accepts the beat this cycle.
REQ-011 in_sk  input  LANES*CIPHERTEXT_WIDTH  secret-key entries, lane 0 in LSBs.
REQ-012 in_ct  input  LANES*CIPHERTEXT_WIDTH  ciphertext "a" entries, or "b" in lane 0 on the body beat.
REQ-013 in_first  input  1  marks the first "a" beat of a ciphertext.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_result  output  PLAINTEXT_WIDTH  decoded plaintext.
REQ-017 out_err  output  1  sticky framing error flag.

Function
REQ-018 A beat SHALL transfer only when in_valid and in_ready are both high; an output SHALL transfer only when out_valid and out_ready are both high.
REQ-019 The FSM SHALL have states ACCUM, BODY and OUT; it SHALL reset to ACCUM with beat counter 0 and accumulator 0.
REQ-020 in_ready SHALL be high in ACCUM and BODY and low in OUT.
REQ-021 In ACCUM, each accepted beat SHALL add the sum of LANES products in_sk[i]*in_ct[i] to the accumulator, all arithmetic unsigned and taken mod q (low CIPHERTEXT_WIDTH bits kept).
REQ-022 A beat accepted with in_first high SHALL replace the accumulator with that beat's sum and set the counter to 1, whatever the prior counter value.
REQ-023 A beat with in_first high while the counter is nonzero, or in BODY, SHALL set out_err; ACCUM restarts per REQ-022.
REQ-024 A beat with in_first low while the counter is 0 SHALL set out_err and SHALL be discarded.
REQ-025 When the counter reaches BEATS, the FSM SHALL move to BODY with the counter cleared.
REQ-026 In BODY, the accepted beat SHALL supply b in lane 0; other lanes and in_sk SHALL be ignored.
REQ-027 On BODY acceptance, phase = (b - acc) mod q; out_result SHALL be registered and the FSM SHALL enter OUT.
REQ-028 out_valid SHALL assert on the cycle after the BODY acceptance, giving 1-cycle latency from b to result.
REQ-029 In OUT, out_valid and out_result SHALL be held stable until out_ready; on transfer the FSM SHALL return to ACCUM and out_valid SHALL drop the next cycle.
REQ-030 Decoded value: result = ((phase*t + R) >> CIPHERTEXT_WIDTH) mod t; the intermediate SHALL be CIPHERTEXT_WIDTH+PLAINTEXT_WIDTH+1 bits wide. R is set by REQ-035.

Reset
REQ-031 Asserting rst_n low SHALL immediately force ACCUM, counter 0, accumulator 0, out_valid 0, out_result 0 and out_err 0.
REQ-032 Reset mid-vector or in OUT SHALL discard the partial or pending result; no output SHALL appear for it.
REQ-033 out_err SHALL clear only on reset.

Configuration
REQ-034 The macro DECRYPT_ROUND_EN SHALL select the decode rounding.
REQ-035 With DECRYPT_ROUND_EN defined, R = q/2 (round to nearest, ties up); without it, R = 0 (truncate).

Verification
REQ-036 All in_sk = 0, b = 88: result 6 with DECRYPT_ROUND_EN, 5 without; b = 87 gives 5 in both builds.
REQ-037 All in_sk = 1, all a = 1 (5 beats), b = 90: acc 10, phase 80, result 5 one cycle after the b beat.
REQ-038 Wrap-around with acc = 8 and b = 0: phase 1016, result 0 with DECRYPT_ROUND_EN, 63 without.
REQ-039 Hold out_ready low for 4 cycles in OUT while in_valid is high: in_ready stays 0, out_result is stable, no beat is consumed; the next vector then decodes correctly.
REQ-040 Assert in_first on beat 3 of a vector: out_err = 1, and the restarted vector decodes correctly.
REQ-041 Pull rst_n low during beat 2, then release and send a full vector: exactly one result appears, for the new vector, and out_err = 0.
